core_if: RTL and testbench

//  Instruction-fetch stage of the i2d core; producer side of the IF->ID interface (if_pc/if_instr, id_halt/flush).

---
 rtl/core_if_pkg.sv | 23 ++
 rtl/core_if_fifo.sv | 59 +++++
 rtl/core_if.sv | 108 ++++++++++
 tb/tb_core_if.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_if_pkg.sv
// rtl/core_if_pkg.sv - shared IF-stage types and constants
// Address/instruction types, bubble encoding and fetch FSM states.
package core_if_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] instr_t;

   localparam logic [5:0]  OPCODE_NOP    = 6'h13;
   localparam logic [25:0] IF_BUBBLE_TAG = 26'(2);
   localparam instr_t      IF_BUBBLE     = {OPCODE_NOP, IF_BUBBLE_TAG};

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DISCARD
   } if_state_t;

   typedef struct packed {
      addr_t  pc;
      instr_t instr;
   } if_entry_t;

endpackage

// File: rtl/core_if_fifo.sv
// rtl/core_if_fifo.sv - {pc,instr} prefetch queue with push/pop/clear
// Clear wins over push/pop; push and pop together on a full queue keep the count.
module core_if_fifo
   import core_if_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  if_entry_t                  i_push_data,
   input  logic                       i_pop,
   input  logic                       i_clear,
   output if_entry_t                  o_head,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   if_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= ptr_inc(r_wptr);
         if (i_pop)  r_rptr <= ptr_inc(r_rptr);
         if (i_push && !i_pop)
            r_count <= r_count + CW'(1);
         else if (i_pop && !i_push)
            r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_clear)
         r_mem[r_wptr] <= i_push_data;
   end

   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/core_if.sv
// rtl/core_if.sv - i2d instruction-fetch stage (IF->ID producer)
// I2D_IF_PREFETCH_EN selects a PF_DEPTH-entry prefetch queue; otherwise one holding register.
module core_if
   import core_if_pkg::*;
#(
   parameter addr_t RESET_VECTOR = 32'h0000_0000,
   parameter int    PF_DEPTH     = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        id_halt,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_bubble
);

`ifdef I2D_IF_PREFETCH_EN
   localparam int QD = PF_DEPTH;
`else
   // single holding register; PF_DEPTH has no effect
   localparam int QD = 1 + 0 * PF_DEPTH;
`endif
   localparam int CW = $clog2(QD) + 1;

   if_state_t     r_state;
   if_state_t     w_state_nxt;
   addr_t         r_fetch_pc;
   addr_t         w_fetch_pc_nxt;
   addr_t         r_addr;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic          w_slot;
   logic [CW-1:0] w_count;
   logic [CW:0]   w_count_nxt;
   if_entry_t     w_head;
   if_entry_t     w_push_data;

   assign w_pop       = !id_halt && !flush && !w_empty;
   assign w_push      = (r_state == REQ) && imem_ack && !flush;
   assign w_push_data = '{pc: r_fetch_pc, instr: imem_rdata};

   // occupancy after this edge; a slot must exist before a new request is issued
   assign w_count_nxt = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
   assign w_slot      = (w_count_nxt < (CW+1)'(QD));

   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      case (r_state)
         IDLE:    if (w_slot) w_state_nxt = REQ;
         REQ: begin
            if (imem_ack) begin
               w_fetch_pc_nxt = r_fetch_pc + 32'd4;
               if (!w_slot) w_state_nxt = IDLE;
            end
         end
         DISCARD: if (imem_ack) w_state_nxt = REQ;
         default: w_state_nxt = IDLE;
      endcase
      // an unretired request must still complete, so it is drained in DISCARD
      if (flush) begin
         w_fetch_pc_nxt = redirect_pc & 32'hFFFF_FFFC;
         w_state_nxt    = (imem_req && !imem_ack) ? DISCARD : REQ;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_fetch_pc <= RESET_VECTOR;
         r_addr     <= RESET_VECTOR;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         if (w_state_nxt != DISCARD)
            r_addr <= w_fetch_pc_nxt;
      end
   end

   assign imem_req  = (r_state != IDLE);
   assign imem_addr = r_addr;

   core_if_fifo #(
      .DEPTH (QD)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .i_clear     (flush),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_empty     (w_empty)
   );

   assign if_bubble = w_empty;
   assign if_pc     = w_empty ? r_fetch_pc : w_head.pc;
   assign if_instr  = w_empty ? IF_BUBBLE  : w_head.instr;

endmodule

// File: tb/tb_core_if.sv
// tb/tb_core_if.sv - scoreboard bench for core_if
// Program-order reference stream, memory responder and output monitor.
module tb_core_if;
   import core_if_pkg::*;

   localparam logic [31:0] RV     = 32'hFFFF_FFF8;
   localparam logic [31:0] BUBBLE = {OPCODE_NOP, 26'd2};
`ifdef I2D_IF_PREFETCH_EN
   localparam int QD = 2;
`else
   localparam int QD = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        id_halt = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_bubble;

   core_if #(
      .RESET_VECTOR (RV),
      .PF_DEPTH     (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .id_halt     (id_halt),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .if_bubble   (if_bubble)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
   endfunction

   logic [31:0] q_pres[$];
   logic [31:0] q_fetch[$];
   logic [31:0] next_pres;
   logic [31:0] next_fetch;

   task automatic top_up();
      while (q_pres.size() < 16) begin
         q_pres.push_back(next_pres);
         next_pres += 32'd4;
      end
      while (q_fetch.size() < 16) begin
         q_fetch.push_back(next_fetch);
         next_fetch += 32'd4;
      end
   endtask

   task automatic restart(input logic [31:0] pc);
      q_pres.delete();
      q_fetch.delete();
      next_pres  = pc & 32'hFFFF_FFFC;
      next_fetch = pc & 32'hFFFF_FFFC;
      top_up();
   endtask

   // memory responder: acks only a raised request, except forced stale acks
   int   ack_mode  = 0;
   logic force_ack = 1'b0;
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
         end else if (imem_req && (ack_mode == 0 || (ack_mode == 1 && $urandom_range(0, 1) == 1))) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
         end else begin
            imem_ack   = 1'b0;
         end
      end
   end

   // monitor: decides at the falling edge what the next rising edge does
   int   occ       = 0;
   logic disc      = 1'b0;
   logic flush_prv = 1'b0;
   logic acc_prv   = 1'b0;
   initial begin
      logic [31:0] e;
      logic        acc;
      restart(RV);
      forever begin
         @(negedge clk);
         if (!rst) begin
            restart(RV);
            occ       = 0;
            disc      = 1'b0;
            flush_prv = 1'b0;
            acc_prv   = 1'b0;
         end else begin
            if (flush_prv)
               chk("bubble_after_flush", {31'd0, if_bubble}, 32'd1);
            else if (acc_prv)
               chk("ack_to_present", {31'd0, if_bubble}, 32'd0);
            if (occ == QD)
               chk("req_drop_when_full", {31'd0, imem_req}, 32'd0);
            if (if_bubble) begin
               chk("bubble_instr", if_instr, BUBBLE);
               chk("bubble_pc", if_pc, q_fetch[0]);
            end else if (!id_halt && !flush) begin
               e = q_pres.pop_front();
               chk("if_pc", if_pc, e);
               chk("if_instr", if_instr, mem_word(e));
               occ--;
            end
            acc = imem_ack && imem_req && !flush && !disc;
            if (acc) begin
               e = q_fetch.pop_front();
               chk("imem_addr", imem_addr, e);
               occ++;
            end
            if (flush) begin
               restart(redirect_pc);
               occ  = 0;
               disc = imem_req && !imem_ack;
            end else if (imem_ack) begin
               disc = 1'b0;
            end
            flush_prv = flush;
            acc_prv   = acc;
            top_up();
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 50) begin
         cycle();
         n++;
      end
      if (!imem_req) chk("wait_req_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_word();
      int n = 0;
      while (if_bubble && n < 50) begin
         cycle();
         n++;
      end
      if (if_bubble) chk("wait_word_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      repeat (3) cycle();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, RV);
      chk("rst_if_pc", if_pc, RV);
      chk("rst_if_instr", if_instr, BUBBLE);
      chk("rst_bubble", {31'd0, if_bubble}, 32'd1);
      rst = 1'b1;
      cycle();
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, RV);
      repeat (20) cycle();

      wait_word();
      id_halt = 1'b1;
      repeat (5) cycle();
      chk("halt_req_off", {31'd0, imem_req}, 32'd0);
      id_halt = 1'b0;
      repeat (10) cycle();

      ack_mode = 2;
      wait_req();
      cycle();
      redirect_pc = 32'h100;
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("discard_req_held", {31'd0, imem_req}, 32'd1);
      repeat (2) cycle();
      ack_mode = 0;
      repeat (12) cycle();

      wait_req();
      redirect_pc = 32'h200;
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("flush_ack_bubble", if_instr, BUBBLE);
      repeat (10) cycle();

      ack_mode = 1;
      repeat (600) begin
         id_halt = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 19) == 0) begin
            flush = 1'b1;
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
         end else begin
            flush = 1'b0;
         end
         cycle();
      end
      flush   = 1'b0;
      id_halt = 1'b0;

      ack_mode = 2;
      wait_req();
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("rst_mid_req", {31'd0, imem_req}, 32'd0);
      chk("rst_mid_addr", imem_addr, RV);
      force_ack = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cycle();
      force_ack = 1'b0;
      ack_mode  = 0;
      chk("restart_req", {31'd0, imem_req}, 32'd1);
      chk("restart_addr", imem_addr, RV);
      repeat (20) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
